// File: rtl/onn_pkg.sv
// Shared definitions for oscillatory neuron variants: FSM encoding, vote values and defaults.
package onn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } onn_state_t;

    localparam int DEF_PHASE_W = 4;
    localparam int DEF_WGT_W   = 3;

    localparam logic signed [1:0] VOTE_POS  = 2'sb01;
    localparam logic signed [1:0] VOTE_NEG  = 2'sb11;
    localparam logic signed [1:0] VOTE_NONE = 2'sb00;

    // Lag sign: positive lag votes up, negative votes down, zero or stale lag abstains.
    function automatic logic signed [1:0] lag_vote(input logic valid, input logic msb, input logic nonzero);
        if (!valid || !nonzero) return VOTE_NONE;
        else if (msb)           return VOTE_NEG;
        else                    return VOTE_POS;
    endfunction

endpackage

// File: rtl/onn_phase_detect_ch.sv
// One coupling channel: rising-edge detect on a neighbour, latch its lag, and emit a +/-1/0 vote.
module onn_phase_detect_ch
    import onn_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic               sclk,
    input  logic               re,
    input  logic               nin,
    input  logic               capture,
    input  logic               drop,
    input  logic [PHASE_W-1:0] rel,
    output logic signed [1:0]  vote
);

    logic               nin_d;
    logic               valid;
    logic [PHASE_W-1:0] lag;
    logic               rise;

    assign rise = nin & ~nin_d;

    always_ff @(posedge sclk) begin
        if (re) begin
            nin_d <= 1'b0;
            valid <= 1'b0;
            lag   <= '0;
        end else begin
            nin_d <= nin;
            // A rise in the drop cycle belongs to the next window, so it wins over the clear.
            if (rise && capture) begin
                lag   <= rel;
                valid <= 1'b1;
            end else if (drop) begin
                valid <= 1'b0;
            end
        end
    end

    assign vote = lag_vote(valid, lag[PHASE_W-1], |lag);

endmodule

// File: rtl/onn_neuron_multi.sv
// Phase-coded oscillatory neuron with N_IN weighted couplings, init-load, freeze and settle detect.
//   state   | meaning
//   ST_IDLE | after reset, oscillator output silent, phase not updated
//   ST_RUN  | oscillating, drop applies the weighted phase vote
//   ST_HOLD | oscillating with phase frozen, lags still captured
module onn_neuron_multi
    import onn_pkg::*;
#(
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int N_IN       = 4,
    parameter int WGT_W      = DEF_WGT_W,
    parameter int STABLE_CNT = 3
) (
    input  logic                    sclk,
    input  logic                    re,
    input  logic [N_IN-1:0]         nin,
    input  logic [N_IN*WGT_W-1:0]   weight,
    input  logic                    ini_load,
    input  logic [PHASE_W-1:0]      ini_phase,
    input  logic                    drop,
    input  logic                    state_check,
    input  logic                    freeze,
    output logic                    nout,
    output logic [PHASE_W-1:0]      phi_out,
    output logic                    state_changed,
    output logic                    settled
);

    localparam int ACC_W = WGT_W + $clog2(N_IN) + 1;
    localparam int SC_W  = $clog2(STABLE_CNT + 1);

    onn_state_t          state;
    logic [PHASE_W-1:0]  cnt;
    logic [PHASE_W-1:0]  rel;
    logic [PHASE_W-1:0]  snap;
    logic [SC_W-1:0]     stable_ctr;
    logic signed [1:0]   vote [N_IN];
    logic signed [ACC_W-1:0] wgt_ext [N_IN];
    logic signed [ACC_W-1:0] acc;
    logic                acc_pos;
    logic                acc_neg;

    assign rel  = cnt - phi_out;
    assign nout = (state != ST_IDLE) && !rel[PHASE_W-1];

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        assign wgt_ext[i] = {{(ACC_W-WGT_W){weight[i*WGT_W+WGT_W-1]}}, weight[i*WGT_W +: WGT_W]};

        onn_phase_detect_ch #(.PHASE_W(PHASE_W)) u_ch (
            .sclk    (sclk),
            .re      (re),
            .nin     (nin[i]),
            .capture (state != ST_IDLE),
            .drop    (drop),
            .rel     (rel),
            .vote    (vote[i])
        );
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (vote[i] == VOTE_POS)      acc = acc + wgt_ext[i];
            else if (vote[i] == VOTE_NEG) acc = acc - wgt_ext[i];
        end
    end

    assign acc_neg = acc[ACC_W-1];
    assign acc_pos = !acc[ACC_W-1] && (acc != '0);

    always_ff @(posedge sclk) begin
        if (re) cnt <= '0;
        else    cnt <= cnt + PHASE_W'(1);
    end

    always_ff @(posedge sclk) begin
        if (re) begin
            state         <= ST_IDLE;
            phi_out       <= '0;
            snap          <= '0;
            state_changed <= 1'b0;
            stable_ctr    <= '0;
        end else if (ini_load) begin
            phi_out       <= ini_phase;
            state         <= (state != ST_IDLE && freeze) ? ST_HOLD : ST_RUN;
            state_changed <= 1'b0;
            stable_ctr    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (freeze) begin
                        state <= ST_HOLD;
                    end else if (drop) begin
                        if (acc_pos)      phi_out <= phi_out + PHASE_W'(1);
                        else if (acc_neg) phi_out <= phi_out - PHASE_W'(1);
                    end
                end
                ST_HOLD: if (!freeze) state <= ST_RUN;
                default: state <= ST_IDLE;
            endcase
            // Check compares the pre-update phase, so a same-cycle drop shows at the next check.
            if (state_check) begin
                snap          <= phi_out;
                state_changed <= (phi_out != snap);
                if (phi_out != snap)                     stable_ctr <= '0;
                else if (stable_ctr != SC_W'(STABLE_CNT)) stable_ctr <= stable_ctr + SC_W'(1);
            end
        end
    end

    assign settled = (stable_ctr == SC_W'(STABLE_CNT));

endmodule

// File: tb/tb_onn_neuron_multi.sv
// Directed bench for onn_neuron_multi: vote vector table plus hand sequences for wrap, freeze, settle, reset.
module tb_onn_neuron_multi;

    logic        sclk = 1'b0;
    logic        re = 1'b1;
    logic [3:0]  nin = '0;
    logic [11:0] weight = '0;
    logic        ini_load = 1'b0;
    logic [3:0]  ini_phase = '0;
    logic        drop = 1'b0;
    logic        state_check = 1'b0;
    logic        freeze = 1'b0;
    logic        nout;
    logic [3:0]  phi_out;
    logic        state_changed;
    logic        settled;

    onn_neuron_multi #(.PHASE_W(4), .N_IN(4), .WGT_W(3), .STABLE_CNT(3)) dut (
        .sclk          (sclk),
        .re            (re),
        .nin           (nin),
        .weight        (weight),
        .ini_load      (ini_load),
        .ini_phase     (ini_phase),
        .drop          (drop),
        .state_check   (state_check),
        .freeze        (freeze),
        .nout          (nout),
        .phi_out       (phi_out),
        .state_changed (state_changed),
        .settled       (settled)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad = 0;
    logic [3:0] m_cnt = '0;
    logic [3:0] exp_phi = '0;
    logic       exp_run = 1'b0;

    always @(posedge sclk) begin
        if (re) m_cnt <= '0;
        else    m_cnt <= m_cnt + 4'd1;
    end

    typedef struct {
        logic [11:0] wgt;
        logic [3:0]  mask;
        logic [15:0] dd;
        int          delta;
    } vec_t;

    vec_t vecs[6];
    vec_t one;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(negedge sclk);
    endtask

    function automatic int model_nout();
        logic [3:0] r;
        r = m_cnt - exp_phi;
        return (exp_run && r < 4'd8) ? 1 : 0;
    endfunction

    task automatic load(input logic [3:0] p);
        ini_phase = p;
        ini_load = 1'b1;
        tick();
        ini_load = 1'b0;
        exp_phi = p;
        exp_run = 1'b1;
    endtask

    task automatic make_edges(input vec_t v);
        logic [3:0] want;
        bit hit;
        weight = v.wgt;
        for (int i = 0; i < 4; i++) begin
            if (v.mask[i]) begin
                want = v.dd[i*4 +: 4];
                hit = 0;
                for (int k = 0; k < 40 && !hit; k++) begin
                    if (4'(m_cnt - exp_phi) == want) hit = 1;
                    else tick();
                end
                if (!hit) chk("edge_wait", 0, 1);
                nin[i] = 1'b1;
                tick();
                nin[i] = 1'b0;
            end
        end
    endtask

    task automatic pulse_drop(input int delta);
        drop = 1'b1;
        tick();
        drop = 1'b0;
        exp_phi = exp_phi + 4'(delta);
    endtask

    task automatic pulse_check();
        state_check = 1'b1;
        tick();
        state_check = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{wgt: {3'b111, 3'd1, 3'd1, 3'd1},       mask: 4'hF,    dd: {4'd1, 4'd14, 4'd3, 4'd2}, delta: 0};
        vecs[1] = '{wgt: {3'd1, 3'd1, 3'd1, 3'd1},         mask: 4'hF,    dd: {4'd1, 4'd14, 4'd3, 4'd2}, delta: 1};
        vecs[2] = '{wgt: {3'b111, 3'b111, 3'b111, 3'b111}, mask: 4'hF,    dd: {4'd5, 4'd4, 4'd3, 4'd2},  delta: -1};
        vecs[3] = '{wgt: {3'd0, 3'd0, 3'b100, 3'd3},       mask: 4'b0011, dd: {4'd0, 4'd0, 4'd8, 4'd1},  delta: 1};
        vecs[4] = '{wgt: {3'd1, 3'd1, 3'd1, 3'd1},         mask: 4'b0000, dd: 16'd0,                     delta: 0};
        vecs[5] = '{wgt: {3'd0, 3'd0, 3'b111, 3'd2},       mask: 4'b0011, dd: {4'd0, 4'd0, 4'd1, 4'd15}, delta: -1};

        re = 1'b1;
        repeat (3) tick();
        re = 1'b0;
        chk("rst_phi", int'(phi_out), 0);
        chk("rst_nout", int'(nout), 0);
        chk("rst_settled", int'(settled), 0);
        chk("rst_changed", int'(state_changed), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("idle_nout", int'(nout), 0);
        end

        load(4'd5);
        chk("load_phi", int'(phi_out), 5);
        for (int k = 0; k < 32; k++) begin
            chk("osc_nout", int'(nout), model_nout());
            tick();
        end

        for (int v = 0; v < 6; v++) begin
            make_edges(vecs[v]);
            pulse_drop(vecs[v].delta);
            chk($sformatf("vote_phi_%0d", v), int'(phi_out), int'(exp_phi));
            chk($sformatf("vote_nout_%0d", v), int'(nout), model_nout());
        end

        one = '{wgt: {3'd0, 3'd0, 3'd0, 3'd1}, mask: 4'b0001, dd: {12'd0, 4'd1}, delta: 1};
        load(4'd15);
        make_edges(one);
        pulse_drop(1);
        chk("wrap_up_phi", int'(phi_out), 0);
        one.dd = {12'd0, 4'd15};
        load(4'd0);
        make_edges(one);
        pulse_drop(-1);
        chk("wrap_down_phi", int'(phi_out), 15);

        one.dd = {12'd0, 4'd1};
        load(4'd7);
        freeze = 1'b1;
        tick();
        make_edges(one);
        pulse_drop(0);
        chk("freeze_hold_phi", int'(phi_out), 7);
        chk("freeze_nout", int'(nout), model_nout());
        freeze = 1'b0;
        tick();
        pulse_drop(0);
        chk("freeze_valid_cleared", int'(phi_out), 7);
        make_edges(one);
        pulse_drop(1);
        chk("unfreeze_phi", int'(phi_out), 8);

        load(4'd3);
        chk("load_clr_settled", int'(settled), 0);
        pulse_check();
        pulse_check();
        chk("settle_1", int'(settled), 0);
        chk("settle_1_chg", int'(state_changed), 0);
        pulse_check();
        chk("settle_2", int'(settled), 0);
        pulse_check();
        chk("settle_3", int'(settled), 1);
        chk("settle_3_chg", int'(state_changed), 0);
        pulse_check();
        chk("settle_sat", int'(settled), 1);
        make_edges(one);
        pulse_drop(1);
        pulse_check();
        chk("change_chg", int'(state_changed), 1);
        chk("change_settled", int'(settled), 0);
        chk("change_phi", int'(phi_out), 4);
        make_edges(one);
        drop = 1'b1;
        state_check = 1'b1;
        tick();
        drop = 1'b0;
        state_check = 1'b0;
        exp_phi = exp_phi + 4'd1;
        chk("same_cycle_chg", int'(state_changed), 0);
        chk("same_cycle_phi", int'(phi_out), 5);
        pulse_check();
        chk("next_check_chg", int'(state_changed), 1);
        load(4'd5);
        chk("load_clr_chg", int'(state_changed), 0);

        load(4'd9);
        repeat (3) tick();
        chk("pre_rst_phi", int'(phi_out), 9);
        re = 1'b1;
        tick();
        re = 1'b0;
        exp_phi = '0;
        exp_run = 1'b0;
        chk("midrst_phi", int'(phi_out), 0);
        chk("midrst_nout", int'(nout), 0);
        chk("midrst_settled", int'(settled), 0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("midrst_idle_nout", int'(nout), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
